sample_fifo: RTL
================

// Module: sample_fifo
// PURPOSE
//   Elastic audio buffer between the UART byte receiver and the I2S driver. Stores 8-bit unsigned mono
//   PCM bytes arriving on byte_ready pulses; hands one sample per sample_tick to the driver.
//   Pre-fills before playback, substitutes silence on underrun, drops bytes on overflow, and raises
//   almost_full for host flow control. Single clock domain (27 MHz).
// PARAMETERS
//   ADDR_W      10    log2 of FIFO depth (DEPTH = 2**ADDR_W bytes)
//   START_LEVEL 512   fill level that must be reached in PRIMING before playback starts (1..DEPTH)
//   HIGH_WM     896   almost_full asserts when level >= HIGH_WM
//   LOW_WM      640   almost_full deasserts when level <= LOW_WM (hysteresis, LOW_WM < HIGH_WM)
//   SILENCE     8'h80 sample emitted while not playing (unsigned-PCM midscale)
// PORTS
//   clk           in   1         system clock
//   rst_n         in   1         synchronous active-low reset
//   data_in       in   8         received byte, valid when byte_ready=1
//   byte_ready    in   1         one-cycle write strobe
//   sample_tick   in   1         one-cycle read strobe from driver, spacing >= 4 clk
//   mono_sample   out  8         registered sample presented to driver
//   sample_valid  out  1         1 when mono_sample came from FIFO, 0 when SILENCE
//   playing       out  1         1 in PLAYING state
//   level         out  ADDR_W+1  current occupancy, 0..DEPTH
//   almost_full   out  1         hysteretic high-watermark flag (drive host RTS/XOFF)
//   overflow      out  1         sticky: a byte was dropped because FIFO was full
//   underrun_cnt  out  8         saturating count of PLAYING->PRIMING underruns
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): wr_ptr=rd_ptr=0, level=0, state=PRIMING, mono_sample=SILENCE,
//     sample_valid=0, playing=0, almost_full=0, overflow=0, underrun_cnt=0. Memory contents not cleared.
//     Reset mid-stream discards all buffered data; pending read pipeline is flushed.
//   - Storage: DEPTH x 8 inferred block RAM, synchronous read. Pointers ADDR_W bits, wrap DEPTH-1 -> 0.
//   - Write: byte_ready=1 and level<DEPTH -> mem[wr_ptr]<=data_in, wr_ptr++. If level==DEPTH the byte is
//     dropped, pointers unchanged, overflow<=1 (stays set until reset).
//   - States: PRIMING, PLAYING.
//     PRIMING: ticks do not pop; on each tick mono_sample<=SILENCE, sample_valid<=0 (2-cycle latency as
//     below). Transition to PLAYING at the edge where level >= START_LEVEL.
//     PLAYING: on tick with level>0 -> pop (rd_ptr++, level--) at tick edge N; RAM data registered at
//     N+1; mono_sample<=data, sample_valid<=1 at edge N+2. On tick with level==0 -> underrun: state<=PRIMING,
//     underrun_cnt++ (saturate at 255), mono_sample<=SILENCE, sample_valid<=0 at N+2.
//   - Latency: mono_sample/sample_valid change exactly 2 cycles after the edge sampling sample_tick and hold
//     until the next tick's update. Byte written at edge W is poppable from edge W+1.
//   - Simultaneous byte_ready and pop in same cycle: both take effect, level unchanged; allowed when full
//     (pop frees the slot, write accepted, no overflow) and when empty in PLAYING is an underrun
//     (write accepted, level becomes 1).
//   - level is registered and exact every cycle; playing==(state==PLAYING).
//   - almost_full: set when level>=HIGH_WM, cleared when level<=LOW_WM, else holds.
//   - All arithmetic unsigned; level ADDR_W+1 bits so DEPTH is representable.
// TESTING
//   1. Reset then 511 bytes, ticks -> level=511, playing=0, mono_sample=8'h80, sample_valid=0 throughout.
//   2. Write byte 512 (0x00..0xFF ramp) -> playing=1 next cycle; ticks return 0x00,0x01,... each 2 cycles
//      after tick with sample_valid=1; level decrements per tick.
//   3. Drain to empty in PLAYING, one more tick -> mono_sample=8'h80, sample_valid=0, underrun_cnt=1,
//      playing=0; refill to 512 -> playback resumes with correct next byte.
//   4. Write 1025 bytes without ticks -> level=1024, overflow=1, byte 1025 lost; readback order intact
//      across pointer wrap (run pointers past 1023 twice).
//   5. Full FIFO, byte_ready and tick same cycle -> level stays 1024, overflow stays 0, new byte read last.
//   6. almost_full: rises at level 896, stays high at 700, falls at 640; rst_n=0 mid-playback clears
//      level, flags, counters and returns mono_sample to 8'h80 at the next edge.

Source files
------------

// File: rtl/sample_fifo.sv
// sample_fifo: elastic 8-bit PCM buffer between the UART receiver and the I2S driver.
// Pre-fills before playback, plays silence on underrun, drops bytes on overflow.
`default_nettype none

module sample_fifo #(
   parameter int         ADDR_W      = 10,
   parameter int         START_LEVEL = 512,
   parameter int         HIGH_WM     = 896,
   parameter int         LOW_WM      = 640,
   parameter logic [7:0] SILENCE     = 8'h80
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        data_in,
   input  logic              byte_ready,
   input  logic              sample_tick,
   output logic [7:0]        mono_sample,
   output logic              sample_valid,
   output logic              playing,
   output logic [ADDR_W:0]   level,
   output logic              almost_full,
   output logic              overflow,
   output logic [7:0]        underrun_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] START_L = (ADDR_W + 1)'(START_LEVEL);
   localparam logic [ADDR_W:0] HIGH_L  = (ADDR_W + 1)'(HIGH_WM);
   localparam logic [ADDR_W:0] LOW_L   = (ADDR_W + 1)'(LOW_WM);

   typedef enum logic {
      PRIMING = 1'b0,
      PLAYING = 1'b1
   } state_t;

   state_t            state;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [7:0]        rd_data;
   logic [7:0]        data_q;
   logic              s1_tick, s1_pop, s2_tick, s2_pop;
   logic              pop, underrun, wr_en;
   logic [ADDR_W:0]   level_nxt;

   always_comb begin
      pop       = sample_tick && (state == PLAYING) && (level != '0);
      underrun  = sample_tick && (state == PLAYING) && (level == '0);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
      wr_en     = byte_ready && ((level != DEPTH_L) || pop);
      level_nxt = level;
      if (wr_en && !pop)
         level_nxt = level + 1'b1;
      else if (!wr_en && pop)
         level_nxt = level - 1'b1;
   end

   // Read-first RAM: when full, the popped slot is the one being rewritten, so the
   // read must be taken at the pop edge to return the old byte.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= data_in;
      rd_data <= mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         state        <= PRIMING;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underrun_cnt <= '0;
         s1_tick      <= 1'b0;
         s1_pop       <= 1'b0;
         s2_tick      <= 1'b0;
         s2_pop       <= 1'b0;
         data_q       <= '0;
         mono_sample  <= SILENCE;
         sample_valid <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         level <= level_nxt;
         if (byte_ready && !wr_en)
            overflow <= 1'b1;
         if (level_nxt >= HIGH_L)
            almost_full <= 1'b1;
         else if (level_nxt <= LOW_L)
            almost_full <= 1'b0;

         case (state)
            PRIMING: if (level >= START_L) state <= PLAYING;
            PLAYING: if (underrun) begin
               state <= PRIMING;
               if (underrun_cnt != 8'hFF)
                  underrun_cnt <= underrun_cnt + 8'd1;
            end
            default: state <= PRIMING;
         endcase

         s1_tick <= sample_tick;
         s1_pop  <= pop;
         s2_tick <= s1_tick;
         s2_pop  <= s1_pop;
         data_q  <= rd_data;
         if (s2_tick) begin
            mono_sample  <= s2_pop ? data_q : SILENCE;
            sample_valid <= s2_pop;
         end
      end
   end

   assign playing = (state == PLAYING);

endmodule

`default_nettype wire
